// File: rtl/in_bus_conditioner.sv
// in_bus_conditioner: synchronises raw switches and button, debounces the
// button and builds the processor in_bus = {btn_level, switch data}.
//
// Parameters:
//   InBusSz        total in_bus width (MSB = button, rest = switches)
//   SyncStages     synchroniser depth per raw input bit (>= 2)
//   DebounceCycles consecutive disagreeing cycles before level changes
// Ports:
//   clk          system clock
//   n_reset      synchronous active-low reset
//   raw_sw       asynchronous switch inputs
//   raw_btn      asynchronous bouncing button, 1 = pressed
//   in_bus       {btn_level, data} to the processor
//   btn_level    debounced button level
//   btn_press    one-cycle pulse on debounced 0->1
//   btn_release  one-cycle pulse on debounced 1->0
// Build option:
//   IN_BUS_HOLD_EN  switch data is latched on each debounced press
//                   instead of being passed through live.

module in_bus_conditioner #(
  parameter int InBusSz        = 10,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 16
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [InBusSz-2:0] raw_sw,
  input  logic               raw_btn,
  output logic [InBusSz-1:0] in_bus,
  output logic               btn_level,
  output logic               btn_press,
  output logic               btn_release
);

  localparam int DataSz = InBusSz - 1;
  localparam int CntSz  =
    (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntSz-1:0] CntMax =
    CntSz'(DebounceCycles - 1);

  logic [SyncStages-1:0] r_btn_sync;
  logic [DataSz-1:0]     r_sw_sync [SyncStages];

  logic              w_sync_btn;
  logic [DataSz-1:0] w_sync_sw;
  logic [DataSz-1:0] w_data;

  logic [CntSz-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  logic w_mismatch;
  logic w_expire;

  // Synchroniser chains, stage 0 samples the raw pins.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_btn_sync <= '0;
      for (int i = 0; i < SyncStages; i++) begin
        r_sw_sync[i] <= '0;
      end
    end else begin
      r_btn_sync <= {r_btn_sync[SyncStages-2:0], raw_btn};
      r_sw_sync[0] <= raw_sw;
      for (int i = 1; i < SyncStages; i++) begin
        r_sw_sync[i] <= r_sw_sync[i-1];
      end
    end
  end

  assign w_sync_btn = r_btn_sync[SyncStages-1];
  assign w_sync_sw  = r_sw_sync[SyncStages-1];

  // A level change only happens once the disagreement has
  // survived the full window; any agreement restarts it.
  always_comb begin
    w_mismatch = 1'b0;
    w_expire   = 1'b0;
    w_mismatch = (w_sync_btn != r_level);
    w_expire   = w_mismatch && (r_cnt == CntMax);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_expire &  w_sync_btn;
      r_release <= w_expire & ~w_sync_btn;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_level <= w_sync_btn;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef IN_BUS_HOLD_EN
  logic [DataSz-1:0] r_hold;

  // Captures the switches on the same edge the level rises.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_hold <= '0;
    end else if (w_expire && w_sync_btn) begin
      r_hold <= w_sync_sw;
    end
  end

  assign w_data = r_hold;
`else
  assign w_data = w_sync_sw;
`endif

  assign in_bus      = {r_level, w_data};
  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: tb/tb_in_bus_conditioner.sv
// tb_in_bus_conditioner: table-driven bench for in_bus_conditioner
// with SyncStages=2, DebounceCycles=4.

module tb_in_bus_conditioner;

  logic       clk;
  logic       n_reset;
  logic [8:0] raw_sw;
  logic       raw_btn;
  logic [9:0] in_bus;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;

  in_bus_conditioner #(
    .InBusSz(10),
    .SyncStages(2),
    .DebounceCycles(4)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .raw_sw(raw_sw),
    .raw_btn(raw_btn),
    .in_bus(in_bus),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [8:0] sw;
    logic       btn;
    logic       lvl;
    logic       prs;
    logic       rel;
    logic [8:0] dlive;
    logic [8:0] dhold;
  } vec_t;

  typedef struct {
    int         row;
    logic [9:0] bus;
    logic       lvl;
    logic       prs;
    logic       rel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total;
  int   bad;
  int   row;

  task automatic add(input logic r, input logic [8:0] sw,
                     input logic b, input logic l,
                     input logic p, input logic rl,
                     input logic [8:0] dl,
                     input logic [8:0] dh);
    vec_t v;
    v.rst_n = r;
    v.sw    = sw;
    v.btn   = b;
    v.lvl   = l;
    v.prs   = p;
    v.rel   = rl;
    v.dlive = dl;
    v.dhold = dh;
    vecs.push_back(v);
  endtask

  task automatic check(input exp_t e);
    total++;
    if (in_bus !== e.bus) begin
      bad++;
      $display("FAIL bus row=%0d got=%h exp=%h",
               e.row, in_bus, e.bus);
    end
    total++;
    if (btn_level !== e.lvl) begin
      bad++;
      $display("FAIL level row=%0d got=%b exp=%b",
               e.row, btn_level, e.lvl);
    end
    total++;
    if (btn_press !== e.prs) begin
      bad++;
      $display("FAIL press row=%0d got=%b exp=%b",
               e.row, btn_press, e.prs);
    end
    total++;
    if (btn_release !== e.rel) begin
      bad++;
      $display("FAIL release row=%0d got=%b exp=%b",
               e.row, btn_release, e.rel);
    end
    total++;
    if (btn_press === 1'b1 && btn_release === 1'b1) begin
      bad++;
      $display("FAIL both_pulses row=%0d got=11 exp=not both",
               e.row);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    n_reset = v.rst_n;
    raw_sw  = v.sw;
    raw_btn = v.btn;
    e.row = row;
    e.lvl = v.lvl;
    e.prs = v.prs;
    e.rel = v.rel;
`ifdef IN_BUS_HOLD_EN
    e.bus = {v.lvl, v.dhold};
`else
    e.bus = {v.lvl, v.dlive};
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard row=%0d got=empty exp=entry",
               row);
    end else begin
      check(sb.pop_front());
    end
    row++;
  endtask

  initial begin
    logic [4:0] bp;
    total   = 0;
    bad     = 0;
    row     = 0;
    n_reset = 1'b0;
    raw_sw  = '0;
    raw_btn = 1'b0;

    // reset held with inputs high
    repeat (3) add(0, 9'h1FF, 1, 0, 0, 0, 9'h000, 9'h000);
    // button already pressed at reset release
    add(1, 9'h1FF, 1, 0, 0, 0, 9'h000, 9'h000);
    repeat (4) add(1, 9'h1FF, 1, 0, 0, 0, 9'h1FF, 9'h000);
    add(1, 9'h1FF, 1, 1, 1, 0, 9'h1FF, 9'h1FF);
    add(1, 9'h1FF, 1, 1, 0, 0, 9'h1FF, 9'h1FF);
    // clean release
    repeat (5) add(1, 9'h1FF, 0, 1, 0, 0, 9'h1FF, 9'h1FF);
    add(1, 9'h1FF, 0, 0, 0, 1, 9'h1FF, 9'h1FF);
    add(1, 9'h1FF, 0, 0, 0, 0, 9'h1FF, 9'h1FF);
    // bouncing press 1,0,1,1,0 then held, switches 0A5
    bp = 5'b01101;
    for (int i = 0; i < 12; i++) begin
      add(1, 9'h0A5, (i < 5) ? bp[i] : 1'b1,
          i >= 10, i == 10, 0,
          (i == 0) ? 9'h1FF : 9'h0A5,
          (i >= 10) ? 9'h0A5 : 9'h1FF);
    end
    // switches change while pressed
    add(1, 9'h1C3, 1, 1, 0, 0, 9'h0A5, 9'h0A5);
    repeat (2) add(1, 9'h1C3, 1, 1, 0, 0, 9'h1C3, 9'h0A5);
    // release keeps held data
    repeat (5) add(1, 9'h1C3, 0, 1, 0, 0, 9'h1C3, 9'h0A5);
    add(1, 9'h1C3, 0, 0, 0, 1, 9'h1C3, 9'h0A5);
    add(1, 9'h1C3, 0, 0, 0, 0, 9'h1C3, 9'h0A5);

    foreach (vecs[i]) step(vecs[i]);

    // reset sampled at edge 4 of a press abandons it
    vecs.delete();
    repeat (3) add(1, 9'h1C3, 1, 0, 0, 0, 9'h1C3, 9'h0A5);
    add(0, 9'h1C3, 1, 0, 0, 0, 9'h000, 9'h000);
    foreach (vecs[i]) step(vecs[i]);
    total++;
    if (dut.r_cnt !== 2'd0) begin
      bad++;
      $display("FAIL cnt_after_reset got=%0d exp=0", dut.r_cnt);
    end
    vecs.delete();
    add(1, 9'h1C3, 0, 0, 0, 0, 9'h000, 9'h000);
    repeat (8) add(1, 9'h1C3, 0, 0, 0, 0, 9'h1C3, 9'h000);
    foreach (vecs[i]) step(vecs[i]);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
